// File: rtl/seq_detect_param.sv
// Serial pattern detector with a runtime-loadable PAT_W-bit pattern.
// Overlap mode is selectable per cycle. Each match gives a registered dout pulse and bumps a saturating counter.
module seq_detect_param #(
    parameter int               PAT_W   = 4,
    parameter int               CNT_W   = 8,
    parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(4'b0101)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             cnt_clr,
    output logic             dout,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int              FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  pat_reg, pat_next;
    logic [PAT_W-1:0]  win_reg, win_next;
    logic [FILL_W-1:0] fill_reg, fill_next;
    logic              dout_reg, dout_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;

    logic [PAT_W-1:0]  nwin;
    logic [FILL_W-1:0] nfill;
    logic [PAT_W-1:0]  bit_eq;
    logic              match;

    assign nwin  = {win_reg[PAT_W-2:0], din};
    assign nfill = (fill_reg == FILL_FULL) ? FILL_FULL : fill_reg + 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < PAT_W; gi++) begin : g_cmp
            assign bit_eq[gi] = (nwin[gi] == pat_reg[gi]);
        end
    endgenerate

    // A load in the same cycle always wins over the data bit.
    assign match   = din_valid && !pat_load && (nfill == FILL_FULL) && (&bit_eq);
    assign cnt_sat = &cnt_reg;

    always_comb begin
        pat_next  = pat_reg;
        win_next  = win_reg;
        fill_next = fill_reg;
        dout_next = 1'b0;
        cnt_next  = cnt_reg;

        if (pat_load) begin
            pat_next  = pat_in;
            win_next  = '0;
            fill_next = '0;
        end else if (din_valid) begin
            if (match) begin
                dout_next = 1'b1;
                if (overlap) begin
                    win_next  = nwin;
                    fill_next = FILL_FULL;
                end else begin
                    win_next  = '0;
                    fill_next = '0;
                end
            end else begin
                win_next  = nwin;
                fill_next = nfill;
            end
        end

        // A clear takes precedence over a simultaneous match.
        if (cnt_clr) begin
            cnt_next = '0;
        end else if (match && !cnt_sat) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_reg  <= PAT_RST;
            win_reg  <= '0;
            fill_reg <= '0;
            dout_reg <= 1'b0;
            cnt_reg  <= '0;
        end else begin
            pat_reg  <= pat_next;
            win_reg  <= win_next;
            fill_reg <= fill_next;
            dout_reg <= dout_next;
            cnt_reg  <= cnt_next;
        end
    end

    assign dout      = dout_reg;
    assign match_cnt = cnt_reg;

endmodule
